apb_master_arb: RTL and testbench
=================================

# apb_master_arb

Arbitrated APB master that shares one APB slave port (such as the CatRecognizer register/enable slave FSM) between `NUM_REQ` internal requesters. It grants one requester at a time using round-robin arbitration. For each grant it drives a standard SETUP→ACCESS APB transfer and returns read data plus a one-cycle completion pulse to the granted requester. It sits between the host/control logic and the APB slave.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters (2..4).
- `ADDR_W`, 8: APB address width.
- `DATA_W`, 32: APB data width.

Ports:
- `pclock` input 1: the only clock; all logic is on its rising edge.
- `presetn` input 1: reset, synchronous and active-low.
- `req` input NUM_REQ: per-requester transfer request, held high until `done`.
- `req_write` input NUM_REQ: per-requester direction (1 = write).
- `req_addr` input NUM_REQ*ADDR_W: per-requester address; requester i occupies slice [i*ADDR_W +: ADDR_W].
- `req_wdata` input NUM_REQ*DATA_W: per-requester write data, sliced the same way.
- `gnt` output NUM_REQ: one-hot grant, high during SETUP and ACCESS of that requester's transfer.
- `done` output NUM_REQ: one-cycle completion pulse to the requester just served.
- `rdata` output DATA_W: read data captured at completion; valid while `done` is high and held until the next completion.
- `psel` output 1: APB select.
- `penable` output 1: APB enable.
- `pwrite` output 1: APB direction.
- `paddr` output ADDR_W: APB address.
- `pwdata` output DATA_W: APB write data.
- `prdata` input DATA_W: APB read data.
- `pready` input 1: APB ready; used only with `APB_PREADY_EN`.

## Operation
- State machine has three states: IDLE, SETUP and ACCESS. All outputs are registered.
- **Reset values.** While `presetn` is low at a rising edge, all of the following become 0: state (IDLE), `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `gnt`, `done`, `rdata`. The round-robin pointer becomes 0.
- **Eligibility.** Requester i is eligible when `req[i]` is high and `done[i]` is low. The requester completing on the current edge is also ineligible on that edge.
- **IDLE.** If any requester is eligible:
  - pick the first eligible requester scanning upward from the pointer, wrapping around;
  - latch its address, data and direction into `paddr`, `pwdata` and `pwrite`;
  - set `gnt`;
  - go to SETUP with `psel`=1 and `penable`=0.
  - Otherwise stay in IDLE with `psel`=0.
- **SETUP.** Always go to ACCESS with `penable`=1. `paddr`, `pwdata` and `pwrite` do not change.
- **ACCESS.** The transfer completes on the edge where it finishes (see Configuration). On that edge:
  - `rdata` ← `prdata` (for writes as well);
  - `done[granted]` ← 1 for one cycle;
  - pointer ← granted+1 mod NUM_REQ;
  - `penable` ← 0.
  - If another requester is eligible, go straight to SETUP for it (back-to-back transfer, `psel` stays 1).
  - Otherwise go to IDLE: `psel`=0, `gnt`=0.
- **Dropped request.** If a requester drops `req` before `done`, the transfer still completes and `done` still pulses. APB transfers are never aborted.
- **Re-request.** A requester may raise `req` again in the cycle after its `done`.
- **Reset mid-transfer.** The transfer is abandoned, no `done` is issued, and the outputs go to their reset values on that edge.

## Timing
- Requests are sampled at edge k in IDLE:
  - SETUP in cycle k+1;
  - ACCESS in cycle k+2;
  - completion at edge k+2 with no wait states;
  - `done` and `rdata` valid in cycle k+3.
- Minimum latency from request to `done` is 3 cycles. Each wait state adds 1 cycle.
- Back-to-back throughput is one transfer per 2 cycles, with no IDLE cycle between transfers.
- With requesters 0 and 1 both continuously requesting and pointer=0, grants alternate 0,1,0,1.

## Configuration
- Macro: `APB_PREADY_EN`.
- **Defined.** ACCESS completes only on an edge where `pready`=1. ACCESS holds and all APB outputs stay stable while `pready`=0. There is no timeout.
- **Undefined.** `pready` is ignored and ACCESS always lasts exactly one cycle.

## Test plan
- **Single write.** Reset, then `req[0]`=1 with write, addr 0x10, wdata 0xDEADBEEF.
  - Expect `psel` in cycle 1, `penable` in cycle 2, `paddr`=0x10, `pwdata`=0xDEADBEEF.
  - Expect `done[0]` in cycle 3 only, then the bus returns to IDLE.
- **Single read.** `req[1]` read at addr 0x04 with the slave returning 0x12345678.
  - Expect `rdata`=0x12345678 with `done[1]`.
  - Expect `rdata` held after `req` drops.
- **Contention.** `req`=2'b11 held for 4 transfers.
  - Expect grants in order 0,1,0,1.
  - Expect `psel` continuously high and `penable` toggling 0,1,0,1 on alternate cycles.
  - Expect exactly one `done` per transfer.
- **No duplicate.** Requester 0 holds `req` high for one cycle after `done[0]`.
  - Expect no second transfer started by that cycle.
  - A re-raise two cycles later gives a new transfer.
- **Wait states (`APB_PREADY_EN`).** `pready` low for 3 ACCESS cycles.
  - Expect ACCESS to last 4 cycles with stable `paddr`/`pwdata`.
  - Expect `done` in the cycle after `pready`=1.
  - Without the macro, the same stimulus gives a 1-cycle ACCESS.
- **Reset mid-transfer.** `presetn`=0 during ACCESS.
  - Expect all outputs 0 on that edge and no `done`.
  - After release, a pending `req` is re-served from requester 0 (pointer=0).

Source files
------------

// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin arbiter driving one APB master port for NUM_REQ requesters.
// Define APB_PREADY_EN to let the slave insert wait states through pready.
module apb_master_arb #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) (
  input  logic                      pclock,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, gidx, gidx_n, base, pick, nxt;
  logic [NUM_REQ-1:0] elig, gnt_n, done_n;
  logic found, fin, launch, psel_n, penable_n, pwrite_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n, rdata_n;
`ifdef APB_PREADY_EN
  assign fin = (state == ACCESS) && pready;
`else
  logic unused_pready;
  assign unused_pready = pready;
  assign fin = state == ACCESS;
`endif
  assign nxt = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
  // On a completing edge the scan already starts past the requester being finished
  assign base = fin ? nxt : ptr;
  assign launch = ((state == IDLE) || fin) && found;
  always_comb begin
    elig = req & ~done;
    if (fin) elig[gidx] = 1'b0;
    found = 1'b0;
    pick = base;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && elig[IW'((int'(base) + k) % NUM_REQ)]) begin
        found = 1'b1;
        pick = IW'((int'(base) + k) % NUM_REQ);
      end
    state_n = state;
    psel_n = psel;
    penable_n = penable;
    pwrite_n = pwrite;
    paddr_n = paddr;
    pwdata_n = pwdata;
    gnt_n = gnt;
    gidx_n = gidx;
    done_n = '0;
    rdata_n = rdata;
    ptr_n = ptr;
    if (state == SETUP) begin
      state_n = ACCESS;
      penable_n = 1'b1;
    end
    if (fin) begin
      rdata_n = prdata;
      done_n[gidx] = 1'b1;
      ptr_n = nxt;
      penable_n = 1'b0;
    end
    if ((state == IDLE) || fin) begin
      state_n = found ? SETUP : IDLE;
      psel_n = found;
      gnt_n = found ? (NUM_REQ'(1) << pick) : '0;
    end
    for (int k = 0; k < NUM_REQ; k++)
      if (launch && pick == IW'(k)) begin
        pwrite_n = req_write[k];
        paddr_n = req_addr[k*ADDR_W +: ADDR_W];
        pwdata_n = req_wdata[k*DATA_W +: DATA_W];
        gidx_n = IW'(k);
      end
  end
  always_ff @(posedge pclock) begin
    if (!presetn) begin
      state <= IDLE;
      psel <= 1'b0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
      gnt <= '0;
      done <= '0;
      rdata <= '0;
      ptr <= '0;
      gidx <= '0;
    end else begin
      state <= state_n;
      psel <= psel_n;
      penable <= penable_n;
      pwrite <= pwrite_n;
      paddr <= paddr_n;
      pwdata <= pwdata_n;
      gnt <= gnt_n;
      done <= done_n;
      rdata <= rdata_n;
      ptr <= ptr_n;
      gidx <= gidx_n;
    end
  end
endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed bench for apb_master_arb with a queue scoreboard fed at stimulus time.
module tb_apb_master_arb;
  logic pclock = 1'b0, presetn = 1'b0, pready = 1'b1;
  logic [1:0] req = '0, req_write = '0, gnt, done;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [31:0] rdata, pwdata, prdata;
  logic psel, penable, pwrite;
  logic [7:0] paddr;
  int n_chk = 0, n_fail = 0;
  typedef struct {int id; logic wr; logic [7:0] a; logic [31:0] wd; logic [31:0] rd;} exp_t;
  exp_t q[$];
  logic [7:0] bus_a = '0;
  logic [31:0] bus_wd = '0;
  logic bus_wr = 1'b0;
  always #5 pclock = ~pclock;
  // Slave model: one fixed register at 0x04, otherwise a pattern derived from the address
  assign prdata = (paddr == 8'h04) ? 32'h12345678 : {24'hA5A5A5, paddr};
  apb_master_arb #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32)) dut (
    .pclock(pclock), .presetn(presetn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic step();
    @(negedge pclock);
  endtask
  task automatic bus(string nm, logic s, logic e, logic [1:0] g);
    chk(nm, 64'({psel, penable, gnt}), 64'({s, e, g}));
  endtask
  task automatic set_req(int i, logic wr, logic [7:0] a, logic [31:0] d);
    req_write[i] = wr;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*32 +: 32] = d;
  endtask
  task automatic push(int id, logic wr, logic [7:0] a, logic [31:0] wd, logic [31:0] rd);
    exp_t e;
    e.id = id; e.wr = wr; e.a = a; e.wd = wd; e.rd = rd;
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge pclock);
      if (done != 2'b00) begin
        if (q.size() == 0) chk("sb_unexpected_done", 64'(done), 64'(0));
        else begin
          e = q.pop_front();
          chk("sb_done_id", 64'(done), 64'(2'b01 << e.id));
          chk("sb_paddr", 64'(bus_a), 64'(e.a));
          chk("sb_pwdata", 64'(bus_wd), 64'(e.wd));
          chk("sb_pwrite", 64'(bus_wr), 64'(e.wr));
          chk("sb_rdata", 64'(rdata), 64'(e.rd));
        end
      end
      if (psel && penable) begin
        bus_a = paddr;
        bus_wd = pwdata;
        bus_wr = pwrite;
      end
    end
  end
  initial begin
`ifdef APB_PREADY_EN
    int dt = 6;
`else
    int dt = 3;
`endif
    logic pe;
    repeat (3) step();
    chk("reset_ctrl", 64'({psel, penable, pwrite, gnt, done}), 64'(0));
    chk("reset_paddr", 64'(paddr), 64'(0));
    chk("reset_pwdata", 64'(pwdata), 64'(0));
    chk("reset_rdata", 64'(rdata), 64'(0));
    // single write
    presetn = 1'b1;
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
    push(0, 1'b1, 8'h10, 32'hDEADBEEF, 32'hA5A5A510);
    req = 2'b01;
    step(); bus("t1_setup", 1'b1, 1'b0, 2'b01);
    step(); bus("t1_access", 1'b1, 1'b1, 2'b01);
    chk("t1_paddr", 64'(paddr), 64'h10);
    chk("t1_pwdata", 64'(pwdata), 64'hDEADBEEF);
    chk("t1_pwrite", 64'(pwrite), 64'(1));
    step(); chk("t1_done", 64'({done, psel, penable, gnt}), 64'({2'b01, 1'b0, 1'b0, 2'b00}));
    req = 2'b00;
    step(); chk("t1_idle", 64'({done, psel, penable, gnt}), 64'(0));
    // single read
    set_req(1, 1'b0, 8'h04, 32'h0);
    push(1, 1'b0, 8'h04, 32'h0, 32'h12345678);
    req = 2'b10;
    repeat (3) step();
    chk("t2_done", 64'(done), 64'(2'b10));
    chk("t2_rdata", 64'(rdata), 64'h12345678);
    req = 2'b00;
    step(); step();
    chk("t2_rdata_held", 64'(rdata), 64'h12345678);
    // contention, grants must alternate 0,1,0,1
    set_req(0, 1'b0, 8'h20, 32'h0);
    set_req(1, 1'b0, 8'h30, 32'h0);
    push(0, 1'b0, 8'h20, 32'h0, 32'hA5A5A520);
    push(1, 1'b0, 8'h30, 32'h0, 32'hA5A5A530);
    push(0, 1'b0, 8'h20, 32'h0, 32'hA5A5A520);
    push(1, 1'b0, 8'h30, 32'h0, 32'hA5A5A530);
    req = 2'b11;
    for (int s = 1; s <= 8; s++) begin
      step();
      bus($sformatf("t3_cycle%0d", s), 1'b1, (s % 2) == 0, (((s - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10);
      if (s == 7) req[0] = 1'b0;
    end
    step(); chk("t3_end", 64'({done, psel, penable}), 64'({2'b10, 1'b0, 1'b0}));
    req = 2'b00;
    step(); bus("t3_idle", 1'b0, 1'b0, 2'b00);
    // no duplicate transfer while done is still high
    set_req(0, 1'b1, 8'h40, 32'h11111111);
    push(0, 1'b1, 8'h40, 32'h11111111, 32'hA5A5A540);
    req = 2'b01;
    repeat (3) step();
    chk("t4_done", 64'(done), 64'(2'b01));
    step(); chk("t4_nodup", 64'({psel, gnt, done}), 64'(0));
    req = 2'b00;
    step();
    set_req(0, 1'b1, 8'h44, 32'h22222222);
    push(0, 1'b1, 8'h44, 32'h22222222, 32'hA5A5A544);
    req = 2'b01;
    step(); bus("t4_re_setup", 1'b1, 1'b0, 2'b01);
    step(); step();
    chk("t4_re_done", 64'(done), 64'(2'b01));
    req = 2'b00;
    step();
    // pready held low for three ACCESS cycles
    set_req(0, 1'b1, 8'h50, 32'hCAFEF00D);
    push(0, 1'b1, 8'h50, 32'hCAFEF00D, 32'hA5A5A550);
    pready = 1'b0;
    req = 2'b01;
    for (int t = 1; t <= 7; t++) begin
      step();
      pe = (t >= 2) && (t < dt);
      chk($sformatf("t5_cycle%0d", t), 64'({psel, penable, done}),
          64'({(t < dt), pe, (t == dt) ? 2'b01 : 2'b00}));
      if (pe) chk($sformatf("t5_stable%0d", t), 64'({paddr, pwdata}), 64'({8'h50, 32'hCAFEF00D}));
      if (t == 5) pready = 1'b1;
      if (t == dt) req = 2'b00;
    end
    // reset during ACCESS, then restart from requester 0
    set_req(1, 1'b0, 8'h70, 32'h0);
    req = 2'b10;
    step(); step();
    bus("t6_access", 1'b1, 1'b1, 2'b10);
    presetn = 1'b0;
    step();
    chk("t6_reset_outs", 64'({psel, penable, pwrite, gnt, done, paddr, pwdata}), 64'(0));
    chk("t6_reset_rdata", 64'(rdata), 64'(0));
    presetn = 1'b1;
    set_req(0, 1'b0, 8'h60, 32'h0);
    push(0, 1'b0, 8'h60, 32'h0, 32'hA5A5A560);
    push(1, 1'b0, 8'h70, 32'h0, 32'hA5A5A570);
    req = 2'b11;
    step(); bus("t6_restart", 1'b1, 1'b0, 2'b01);
    step(); step();
    chk("t6_done0", 64'(done), 64'(2'b01));
    req[0] = 1'b0;
    step(); step();
    chk("t6_done1", 64'(done), 64'(2'b10));
    req = 2'b00;
    repeat (3) step();
    chk("sb_empty", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
